snap_capture_ctrl: RTL

//  Sequencer for a snapshot BRAM. Drives port A of the dual-port block
//  (128-bit data, 10-bit word address); the CPU reads port B.

---
 rtl/snap_pkg.sv | 16 +
 rtl/snap_capture_ctrl_if.sv | 29 ++
 rtl/snap_edge_det.sv | 21 ++
 rtl/snap_capture_ctrl.sv | 132 +++++++++++++
 4 files changed

// File: rtl/snap_pkg.sv
// Shared types and default sizes for the snapshot-capture blocks.
package snap_pkg;

    localparam int SNAP_DW   = 128;
    localparam int SNAP_AW   = 10;
    localparam int SNAP_DLYW = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        DELAY   = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } snap_state_t;

endpackage

// File: rtl/snap_capture_ctrl_if.sv
// Sample stream in and BRAM port A out of the snapshot sequencer.
// din_vld qualifies din/trig in the same cycle and is always accepted (no ready);
// bram_we qualifies bram_addr/bram_wr_data in the same cycle.
interface snap_capture_ctrl_if
    import snap_pkg::*;
#(
    parameter int DW = SNAP_DW,
    parameter int AW = SNAP_AW
) ();

    logic          din_vld;
    logic          trig;
    logic [DW-1:0] din;
    logic          bram_we;
    logic          bram_en_a;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_wr_data;

    modport master (
        input  din_vld, trig, din,
        output bram_we, bram_en_a, bram_addr, bram_wr_data
    );

    modport slave (
        output din_vld, trig, din,
        input  bram_we, bram_en_a, bram_addr, bram_wr_data
    );

endinterface

// File: rtl/snap_edge_det.sv
// One-bit rising-edge detector; rise is high in the cycle where d is 1 and was 0.
module snap_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic d_q;
    logic d_d;

    always_comb d_d = d;

    always_ff @(posedge clk) begin
        if (rst) d_q <= 1'b0;
        else     d_q <= d_d;
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/snap_capture_ctrl.sv
// Snapshot BRAM sequencer: arm, wait for (optionally delayed) trigger, then write
// consecutive valid samples to BRAM port A through a single output register.
module snap_capture_ctrl
    import snap_pkg::*;
#(
    parameter int DW   = SNAP_DW,
    parameter int AW   = SNAP_AW,
    parameter int DLYW = SNAP_DLYW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ctrl_arm,
    input  logic                ctrl_trig_ext,
    input  logic [DLYW-1:0]     ctrl_delay,
    input  logic [AW-1:0]       ctrl_len,
    snap_capture_ctrl_if.master bus,
    output logic                status_done,
    output logic                status_busy,
    output logic [AW:0]         status_count,
    output snap_state_t         dbg_state
);

    logic arm_edge;

    snap_edge_det u_arm_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (ctrl_arm),
        .rise (arm_edge)
    );

    snap_state_t     state_q, state_d;
    logic            ext_q, ext_d;
    logic [DLYW-1:0] dly_q, dly_d;
    logic [AW:0]     target_q, target_d;
    logic [AW:0]     count_q, count_d;
    logic [AW:0]     count_inc;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   data_q, data_d;
    logic            trig_evt;
    logic            wr_issue;

    assign count_inc = count_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        ext_d    = ext_q;
        dly_d    = dly_q;
        target_d = target_q;
        count_d  = count_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        trig_evt = 1'b0;
        wr_issue = 1'b0;

        // An arm edge overrides anything the stream does in the same cycle.
        if (arm_edge) begin
            state_d  = ARMED;
            ext_d    = ctrl_trig_ext;
            dly_d    = ctrl_delay;
            target_d = (ctrl_len == '0) ? {1'b1, {AW{1'b0}}} : {1'b0, ctrl_len};
            count_d  = '0;
            addr_d   = '0;
        end else begin
            case (state_q)
                ARMED: begin
                    trig_evt = ext_q ? (bus.din_vld & bus.trig) : 1'b1;
                    if (trig_evt) begin
                        if (dly_q != '0) begin
                            state_d = DELAY;
                        end else begin
                            state_d  = CAPTURE;
                            // Only an external trigger sample is itself captured.
                            wr_issue = ext_q;
                        end
                    end
                end
                DELAY: begin
                    if (bus.din_vld) begin
                        dly_d = dly_q - 1'b1;
                        if (dly_q == DLYW'(1)) state_d = CAPTURE;
                    end
                end
                CAPTURE: wr_issue = bus.din_vld;
                default: ;
            endcase

            if (wr_issue) begin
                we_d    = 1'b1;
                addr_d  = count_q[AW-1:0];
                data_d  = bus.din;
                count_d = count_inc;
                if (count_inc == target_q) state_d = DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ext_q    <= 1'b0;
            dly_q    <= '0;
            target_q <= '0;
            count_q  <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            ext_q    <= ext_d;
            dly_q    <= dly_d;
            target_q <= target_d;
            count_q  <= count_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

    assign bus.bram_we      = we_q;
    assign bus.bram_en_a    = we_q;
    assign bus.bram_addr    = addr_q;
    assign bus.bram_wr_data = data_q;

    assign status_done  = (state_q == DONE);
    assign status_busy  = (state_q == ARMED) || (state_q == DELAY) || (state_q == CAPTURE);
    assign status_count = count_q;
    assign dbg_state    = state_q;

endmodule
